// File: rtl/song_pkg.sv
// Shared constants, state encoding and nibble helpers for the song player and the song library.
package song_pkg;

    localparam int unsigned NOTES  = 56;
    localparam int unsigned NOTE_W = 4;
    localparam int unsigned SONG_W = NOTES * NOTE_W;
    localparam int unsigned IDX_W  = $clog2(NOTES);

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
    localparam logic [NOTE_W-1:0] NOTE_SKIP = 4'hF;
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(NOTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SONG_SEL_0,
        SONG_SEL_1,
        SONG_SEL_2,
        SONG_SEL_3
    } song_sel_e;

    // Nibble idx of a packed song bus; nibble 0 sits in the LSBs.
    function automatic logic [NOTE_W-1:0] nibble_at(input logic [SONG_W-1:0] bus,
                                                    input logic [IDX_W-1:0]  idx);
        return bus[{idx, 2'b00} +: NOTE_W];
    endfunction

    // A nibble with the skip code or a zero duration is passed over in one cycle.
    function automatic logic is_skip(input logic [NOTE_W-1:0] code,
                                     input logic [NOTE_W-1:0] dur);
        return (code == NOTE_SKIP) || (dur == NOTE_W'(0));
    endfunction

endpackage

// File: rtl/song_player_if.sv
// Control, song payload and note-output signals between the player and its controller.
interface song_player_if;
    import song_pkg::*;

    logic              start;
    logic              stop;
    logic              pause;
    logic [SONG_W-1:0] song_packed;
    logic [SONG_W-1:0] time_continue;
    logic [NOTE_W-1:0] note;
    logic [IDX_W-1:0]  note_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, pause, song_packed, time_continue,
        input  note, note_idx, busy, done
    );

    modport slave (
        input  start, stop, pause, song_packed, time_continue,
        output note, note_idx, busy, done
    );

endinterface

// File: rtl/song_player_tick_gen.sv
// Duration prescaler: one-cycle tick every TICK_DIV enabled cycles, clearable at note boundaries.
module tick_gen #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Combinational so a note's final unit ends in the same cycle the prescaler wraps.
    assign tick = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/song_player.sv
// Song sequencer: snapshots a packed song on start and steps through it MSB-first, one note per duration.
module song_player
    import song_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    song_player_if.slave  bus
);

    state_e            state_q, state_nxt;
    logic [SONG_W-1:0] song_q, dur_q;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [NOTE_W-1:0] unit_q, unit_nxt;
    logic [NOTE_W-1:0] note_q, note_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    logic [SONG_W-1:0] song_src, dur_src;
    logic [NOTE_W-1:0] cur_code, cur_dur, nxt_code, nxt_dur, prev_dur;
    logic              cur_skip, note_end, tick, tick_en, tick_clr;

    // In LOAD the snapshot is being taken this very edge, so read the live buses.
    assign song_src = (state_q == ST_LOAD) ? bus.song_packed   : song_q;
    assign dur_src  = (state_q == ST_LOAD) ? bus.time_continue : dur_q;

    assign cur_code = nibble_at(song_src, idx_q);
    assign cur_dur  = nibble_at(dur_src, idx_q);
    assign prev_dur = nibble_at(dur_src, idx_q - IDX_W'(1));
    assign nxt_code = nibble_at(song_src, idx_nxt);
    assign nxt_dur  = nibble_at(dur_src, idx_nxt);
    assign cur_skip = is_skip(cur_code, cur_dur);

    assign tick_en  = (state_q == ST_PLAY) && !cur_skip;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        unit_nxt  = unit_q;
        tick_clr  = 1'b0;
        note_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_clr = 1'b1;
                if (bus.start) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = IDX_FIRST;
                end
            end
            ST_LOAD: begin
                tick_clr  = 1'b1;
                unit_nxt  = cur_dur;
                state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                note_end = cur_skip || (tick && (unit_q == NOTE_W'(1)));
                if (!note_end && tick) begin
                    unit_nxt = unit_q - NOTE_W'(1);
                end
                if (note_end) begin
                    if (idx_q == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx_q - IDX_W'(1);
                        unit_nxt  = prev_dur;
                        tick_clr  = 1'b1;
                        state_nxt = bus.pause ? ST_PAUSE : ST_PLAY;
                    end
                end else if (bus.pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!bus.pause) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (bus.stop) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            unit_nxt  = '0;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        note_nxt = NOTE_REST;
        if ((state_nxt == ST_PLAY) && !is_skip(nxt_code, nxt_dur)) begin
            note_nxt = nxt_code;
        end
        busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_PLAY) || (state_nxt == ST_PAUSE);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            unit_q  <= '0;
            note_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            song_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            unit_q  <= unit_nxt;
            note_q  <= note_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            if (state_q == ST_LOAD) begin
                song_q <= bus.song_packed;
                dur_q  <= bus.time_continue;
            end
        end
    end

    assign bus.note     = note_q;
    assign bus.note_idx = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: two instances, TICK_DIV=4 and TICK_DIV=2.
module tb_song_player;
    import song_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    song_player_if bus4 ();
    song_player_if bus2 ();

    song_player #(.TICK_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    song_player #(.TICK_DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on bus2 and advance to the first PLAY cycle.
    task automatic start2(input logic [SONG_W-1:0] song, input logic [SONG_W-1:0] tc);
        bus2.song_packed   = song;
        bus2.time_continue = tc;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus4.note !== 4'h0 || bus4.note_idx !== 6'd0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut4: note=%0h idx=%0d busy=%b done=%b, want all 0",
                     bus4.note, bus4.note_idx, bus4.busy, bus4.done);
        end
        checks++;
        if (bus2.note !== 4'h0 || bus2.note_idx !== 6'd0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: note=%0h idx=%0d busy=%b done=%b, want all 0",
                     bus2.note, bus2.note_idx, bus2.busy, bus2.done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int bad;
        int n;
        bus4.song_packed   = {4'h0, 4'h2, 4'h0, 4'h3, {52{4'h1}}};
        bus4.time_continue = {56{4'h5}};
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.note !== 4'h0 || bus4.note_idx !== 6'd55) begin
            errors++;
            $display("FAIL basic_load: busy=%b note=%0h idx=%0d, want 1 0 55",
                     bus4.busy, bus4.note, bus4.note_idx);
        end
        step();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus4.note !== 4'h0 || bus4.note_idx !== 6'd55) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_note55: %0d bad cycles, want 0 (note 0 idx 55 for 20 cycles)", bad);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus4.note !== 4'h2 || bus4.note_idx !== 6'd54) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_note54: %0d bad cycles, want 0 (note 2 idx 54 for 20 cycles)", bad);
        end
        checks++;
        if (bus4.note !== 4'h0 || bus4.note_idx !== 6'd53) begin
            errors++;
            $display("FAIL basic_note53: note=%0h idx=%0d, want 0 53", bus4.note, bus4.note_idx);
        end
        n = 40;
        while (bus4.done !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1120) begin
            errors++;
            $display("FAIL basic_done_time: done at %0d cycles after first PLAY, want 1120", n);
        end
        checks++;
        if (bus4.busy !== 1'b0 || bus4.note !== 4'h0) begin
            errors++;
            $display("FAIL basic_done_cycle: busy=%b note=%0h, want 0 0", bus4.busy, bus4.note);
        end
        step();
        checks++;
        if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b busy=%b after pulse, want 0 0", bus4.done, bus4.busy);
        end
    endtask

    task automatic test_skips();
        logic [SONG_W-1:0] tc;
        int bad;
        int n;
        tc = {56{4'h5}};
        tc[48*4 +: 4] = 4'h0;
        start2({{6{4'hF}}, 4'h4, {49{4'h1}}}, tc);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus2.note !== 4'h0 || bus2.note_idx !== 6'(55 - c)) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL skip_codes: %0d bad cycles, want 0 (note 0 idx 55..50)", bad);
        end
        bad = 0;
        for (int c = 6; c < 16; c++) begin
            if (bus2.note !== 4'h4 || bus2.note_idx !== 6'd49) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL skip_first_real: %0d bad cycles, want 0 (note 4 idx 49 at cycles 6..15)", bad);
        end
        checks++;
        if (bus2.note !== 4'h0 || bus2.note_idx !== 6'd48) begin
            errors++;
            $display("FAIL skip_dur0: note=%0h idx=%0d, want 0 48", bus2.note, bus2.note_idx);
        end
        step();
        checks++;
        if (bus2.note !== 4'h1 || bus2.note_idx !== 6'd47) begin
            errors++;
            $display("FAIL skip_after_dur0: note=%0h idx=%0d, want 1 47", bus2.note, bus2.note_idx);
        end
        n = 17;
        while (bus2.done !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 497) begin
            errors++;
            $display("FAIL skip_done_time: done at %0d, want 497", n);
        end
        step();
    endtask

    task automatic test_pause();
        int bad;
        int n;
        int on;
        start2({4'h3, {55{4'h1}}}, {56{4'hA}});
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus2.note !== 4'h3) bad++;
            step();
        end
        if (bus2.note !== 4'h3) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pause_pre: %0d bad cycles, want 0 (note 3 for cycles 0..10)", bad);
        end
        bus2.pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus2.note !== 4'h0 || bus2.busy !== 1'b1 || bus2.note_idx !== 6'd55) bad++;
        end
        bus2.pause = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pause_hold: %0d bad paused cycles, want 0 (note 0 busy 1 idx 55)", bad);
        end
        step();
        n = 18;
        on = 0;
        while (bus2.note === 4'h3 && on < 100) begin
            on++;
            step();
            n++;
        end
        checks++;
        if (on !== 9) begin
            errors++;
            $display("FAIL pause_resume_on: %0d on-cycles after pause, want 9", on);
        end
        checks++;
        if (bus2.note !== 4'h1 || bus2.note_idx !== 6'd54) begin
            errors++;
            $display("FAIL pause_next_note: note=%0h idx=%0d, want 1 54", bus2.note, bus2.note_idx);
        end
        while (bus2.done !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1127) begin
            errors++;
            $display("FAIL pause_done_time: done at %0d, want 1127", n);
        end
        step();
    endtask

    task automatic test_stop();
        int n;
        int bad;
        start2({56{4'h2}}, {56{4'h1}});
        n = 0;
        while (bus2.note_idx !== 6'd30 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 50) begin
            errors++;
            $display("FAIL stop_reach_idx30: reached after %0d cycles, want 50", n);
        end
        bus2.stop = 1'b1;
        step();
        bus2.stop = 1'b0;
        checks++;
        if (bus2.busy !== 1'b0 || bus2.note !== 4'h0 || bus2.done !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: busy=%b note=%0h done=%b, want 0 0 0", bus2.busy, bus2.note, bus2.done);
        end
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus2.done !== 1'b0 || bus2.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stop_no_done: %0d cycles with done/busy, want 0", bad);
        end
        start2({56{4'h2}}, {56{4'h1}});
        checks++;
        if (bus2.note_idx !== 6'd55 || bus2.note !== 4'h2 || bus2.busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_restart: idx=%0d note=%0h busy=%b, want 55 2 1",
                     bus2.note_idx, bus2.note, bus2.busy);
        end
        bus2.stop = 1'b1;
        step();
        bus2.stop = 1'b0;
        step();
    endtask

    task automatic test_hazards();
        start2({56{4'h5}}, {56{4'h3}});
        bus2.song_packed   = {56{4'h7}};
        bus2.time_continue = {56{4'h1}};
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        checks++;
        if (bus2.note !== 4'h5 || bus2.note_idx !== 6'd55 || bus2.busy !== 1'b1) begin
            errors++;
            $display("FAIL hazard_start_busy: note=%0h idx=%0d busy=%b, want 5 55 1",
                     bus2.note, bus2.note_idx, bus2.busy);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus2.note !== 4'h5 || bus2.note_idx !== 6'd55) begin
            errors++;
            $display("FAIL hazard_dur_snapshot: note=%0h idx=%0d at cycle 5, want 5 55",
                     bus2.note, bus2.note_idx);
        end
        step();
        checks++;
        if (bus2.note !== 4'h5 || bus2.note_idx !== 6'd54) begin
            errors++;
            $display("FAIL hazard_song_snapshot: note=%0h idx=%0d at cycle 6, want 5 54",
                     bus2.note, bus2.note_idx);
        end
        bus2.stop = 1'b1;
        step();
        bus2.stop = 1'b0;
        step();
        bus2.start = 1'b1;
        bus2.stop  = 1'b1;
        step();
        bus2.start = 1'b0;
        bus2.stop  = 1'b0;
        checks++;
        if (bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL hazard_start_stop: busy=%b, want 0", bus2.busy);
        end
        step();
        checks++;
        if (bus2.busy !== 1'b0 || bus2.note !== 4'h0) begin
            errors++;
            $display("FAIL hazard_start_stop_hold: busy=%b note=%0h, want 0 0", bus2.busy, bus2.note);
        end
    endtask

    task automatic test_reset_midsong();
        int bad;
        start2({56{4'h6}}, {56{4'h2}});
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus2.note !== 4'h6 || bus2.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: note=%0h busy=%b, want 6 1", bus2.note, bus2.busy);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (bus2.note !== 4'h0 || bus2.note_idx !== 6'd0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: note=%0h idx=%0d busy=%b done=%b, want all 0",
                     bus2.note, bus2.note_idx, bus2.busy, bus2.done);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.note !== 4'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_stays_idle: %0d active cycles after reset, want 0", bad);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus4.start = 1'b0; bus4.stop = 1'b0; bus4.pause = 1'b0;
        bus4.song_packed = '0; bus4.time_continue = '0;
        bus2.start = 1'b0; bus2.stop = 1'b0; bus2.pause = 1'b0;
        bus2.song_packed = '0; bus2.time_continue = '0;

        test_reset();
        test_basic();
        test_skips();
        test_pause();
        test_stop();
        test_hazards();
        test_reset_midsong();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_player.md
# song_player

Sequencer directly downstream of the song library. On `start` it snapshots the 56-note `song_packed` / `time_continue` pair, then steps through the notes MSB-first, holding each note code for its duration, and presents the current note to the tone generator. It supports pause, stop, skip codes, and a one-cycle `done` pulse.

## Interface
Parameters:
- `NOTES`, 56, notes per song.
- `NOTE_W`, 4, bits per note code and per duration field.
- `TICK_DIV`, 10_000_000, clock cycles per duration unit (0.1 s at 100 MHz); must be ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  pulse; begins playback from IDLE.
- `stop`  in  1  pulse; aborts playback.
- `pause`  in  1  level; freezes playback while high.
- `song_packed`  in  224  note codes; nibble 55 is played first.
- `time_continue`  in  224  durations in units; nibble i belongs to note i.
- `note`  out  4  current note code to the tone generator; 0 = silence.
- `note_idx`  out  6  index of the nibble being played, 55 down to 0.
- `busy`  out  1  high in LOAD, PLAY and PAUSE.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- Note codes: 0 = rest, 1–7 = scale degrees, 4'hF = skip. Codes 8–E are played as given; tone mapping is downstream.
- States: IDLE, LOAD, PLAY, PAUSE, DONE.
- **IDLE:** `note`=0, `busy`=0. `start` → LOAD.
- **LOAD:** latch both 224-bit buses into internal registers. Set `note_idx`=55 and load that nibble's duration. → PLAY.
  - Input changes after LOAD have no effect until the next `start`.
- **PLAY:** `note` = code of the current nibble. The tick prescaler is cleared at every note load. The note is held exactly dur×TICK_DIV cycles, then `note_idx` decrements.
- **Skip rule:** code F *or* dur 0 makes the nibble a skip. A skip occupies exactly 1 cycle with `note`=0, then advances.
- **End of song:** when nibble 0 finishes → DONE.
- **PAUSE:** entered when `pause`=1 in PLAY. The prescaler and unit counters freeze and `note`=0. On `pause`=0, return to PLAY with the remaining count intact. `pause` is ignored in IDLE and LOAD.
- **DONE:** `done`=1 and `note`=0 for one cycle. → IDLE.
- **Priority:** `rst_n` > `stop` > `pause` > `start`.
  - `stop` in any state → IDLE next cycle, `note`=0, no `done` pulse.
  - `start` while `busy` is ignored.
  - `start` in the same cycle as `stop` → IDLE.
- **Reset values:** all outputs 0, state IDLE, latched registers 0. Reset mid-song discards everything.
- **Arithmetic:** the unit counter is 4 bits (max 15 units). The prescaler is $clog2(TICK_DIV) bits and wraps to 0 on tick. `note_idx` does not wrap below 0.

## Timing
- `start` sampled at edge k → LOAD during cycle k+1 → first PLAY cycle k+2, when `note` shows nibble 55.
- A playable note occupies dur×TICK_DIV consecutive PLAY cycles. The next note appears on the following cycle, with no gap cycle.
- Paused cycles add to wall time only; they do not count toward the note's duration.
- `busy` falls in the DONE cycle; `done` and `busy` are never high together.
- Total PLAY cycles = Σ(dur×TICK_DIV) over playable notes + number of skips.

## Structure
- Package `song_pkg`: `NOTES`, `NOTE_W`, `NOTE_REST`=4'h0, `NOTE_SKIP`=4'hF, the state enum, and the song-select codes shared with the library.
- Sub-module `tick_gen`:
  - Inputs `clk`, `rst_n`, `clr`, `en`; output `tick`.
  - `tick` is a one-cycle pulse every TICK_DIV enabled cycles.
  - `clr` forces the count to 0.
- The player owns the FSM, the latch/index registers and the unit counter.

## Test plan
- **Basic song:** TICK_DIV=4, all durations 5, song begins {0,2,0,3,…} → `note`=0 for 20 cycles from k+2, then `note`=2 for 20 cycles, `note_idx` 55→54→53. `done` occurs exactly 1120 PLAY cycles after k+2.
- **Skips:** top 6 nibbles = F, rest durations 5, TICK_DIV=2 → 6 cycles of `note`=0 with `note_idx` 55..50. The first real note starts at k+8 and lasts 10 cycles. A nibble with dur 0 likewise takes 1 cycle.
- **Pause:** pause for 7 cycles midway through a 20-cycle note → `note`=0 during the pause, then the note resumes. The note's total on-time is still 20 and `done` is delayed by 7.
- **Stop:** `stop` at note_idx 30 → IDLE next cycle, `note`=0, `busy`=0, no `done`. A following `start` restarts at idx 55.
- **Input and start hazards:** change `song_packed` during PLAY → output unaffected. `start` while busy → ignored. `start`+`stop` in the same cycle → stays IDLE.
- **Reset:** assert `rst_n`=0 for one cycle during PLAY → all outputs 0 on the next edge; no `done`.
